// File: rtl/sm2_pkg.sv
// Shared constants, state encoding and word-mask helper for the SM2 KDF keystream consumer.
package sm2_pkg;

   localparam int KDF_MAXLEN = 4;
   localparam int KDF_BLK_W  = 256;
   localparam int WORD_W     = 32;
   localparam int KEY_W      = KDF_BLK_W * KDF_MAXLEN;
   localparam int NWORDS_MAX = KEY_W / WORD_W;
   localparam int IDX_W      = $clog2(8 * KDF_MAXLEN) + 1;
   localparam int SEL_W      = IDX_W - 1;

   // One-hot state encoding
   typedef enum logic [5:0] {
      S_IDLE   = 6'b000001,
      S_WAITK  = 6'b000010,
      S_CHECK  = 6'b000100,
      S_STREAM = 6'b001000,
      S_FIN    = 6'b010000,
      S_ERR    = 6'b100000
   } state_t;

   // Full word unless this is the last word of a partial message; then only the top rem bits.
   function automatic logic [WORD_W-1:0] word_mask(input logic [4:0] rem, input logic last);
      logic [WORD_W-1:0] m;
      m = '1;
      if (last && rem != 5'd0)
         m = ~({WORD_W{1'b1}} >> rem);
      return m;
   endfunction

endpackage

// File: rtl/sm2_kdf_xor_if.sv
// Control, keystream and message handshake signals between the KDF consumer and its neighbours.
interface sm2_kdf_xor_if;

   logic                       start;
   logic [31:0]                klen;
   logic [sm2_pkg::KEY_W-1:0]  kin;
   logic                       kin_valid;
   logic [sm2_pkg::WORD_W-1:0] din;
   logic                       din_valid;
   logic                       din_ready;
   logic [sm2_pkg::WORD_W-1:0] dout;
   logic                       dout_valid;
   logic                       dout_ready;
   logic                       busy;
   logic                       done;
   logic                       zero_key;
   logic                       len_err;

   modport master (
      output start, klen, kin, kin_valid, din, din_valid, dout_ready,
      input  din_ready, dout, dout_valid, busy, done, zero_key, len_err
   );

   modport slave (
      input  start, klen, kin, kin_valid, din, din_valid, dout_ready,
      output din_ready, dout, dout_valid, busy, done, zero_key, len_err
   );

endinterface

// File: rtl/sm2_kdf_xor.sv
// Captures the KDF keystream, rejects an all-zero key over klen bits, then XORs it with the
// 32-bit message stream under a valid/ready handshake with one-word output buffering.
//
// state  | meaning
// IDLE   | waiting for start
// WAITK  | klen latched, waiting for keystream from the KDF
// CHECK  | OR-reduce key words 0..nwords-1 (last one masked), one word per cycle
// STREAM | XOR message words with key words, one output word buffered
// FIN    | done pulse after the last word drains
// ERR    | done pulse after a length error or an all-zero key
module sm2_kdf_xor
   import sm2_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   sm2_kdf_xor_if.slave  bus
);

   state_t              state;
   logic [KEY_W-1:0]    key_r;
   logic [IDX_W-1:0]    nwords;
   logic [4:0]          rem;
   logic [IDX_W-1:0]    idx;
   logic [WORD_W-1:0]   acc;
   logic [WORD_W-1:0]   dout_r;
   logic                dout_valid_r;
   logic                zero_key_r;
   logic                len_err_r;

   logic [WORD_W-1:0]   key_words [NWORDS_MAX];
   logic [WORD_W-1:0]   cur_key;
   logic [WORD_W-1:0]   cur_mask;
   logic [WORD_W-1:0]   chk_word;
   logic [IDX_W-1:0]    nwords_calc;
   logic                klen_bad;
   logic                idx_last;
   logic                all_in;
   logic                din_ready_c;
   logic                xfer;

   for (genvar i = 0; i < NWORDS_MAX; i++) begin : g_key_words
      assign key_words[i] = key_r[KEY_W-1-WORD_W*i -: WORD_W];
   end

   // Word select uses the low index bits; idx==nwords only occurs once every word is in.
   assign cur_key     = key_words[idx[SEL_W-1:0]];
   assign idx_last    = (idx == nwords - IDX_W'(1));
   assign all_in      = (idx == nwords);
   assign cur_mask    = word_mask(rem, idx_last);
   assign chk_word    = cur_key & cur_mask;

   assign klen_bad    = (bus.klen == 32'd0) || (bus.klen > 32'(KEY_W));
   assign nwords_calc = IDX_W'((bus.klen[10:0] + 11'd31) >> 5);

   assign din_ready_c = (state == S_STREAM) && !all_in && (!dout_valid_r || bus.dout_ready);
   assign xfer        = bus.din_valid && din_ready_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         key_r        <= '0;
         nwords       <= '0;
         rem          <= '0;
         idx          <= '0;
         acc          <= '0;
         dout_r       <= '0;
         dout_valid_r <= 1'b0;
         zero_key_r   <= 1'b0;
         len_err_r    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  zero_key_r <= 1'b0;
                  len_err_r  <= 1'b0;
                  nwords     <= nwords_calc;
                  rem        <= bus.klen[4:0];
                  idx        <= '0;
                  acc        <= '0;
                  if (klen_bad) begin
                     len_err_r <= 1'b1;
                     state     <= S_ERR;
                  end else begin
                     state     <= S_WAITK;
                  end
               end
            end

            S_WAITK: begin
               if (bus.kin_valid) begin
                  key_r <= bus.kin;
                  state <= S_CHECK;
               end
            end

            S_CHECK: begin
               if (idx_last) begin
                  idx <= '0;
                  acc <= '0;
                  if ((acc | chk_word) == '0) begin
                     zero_key_r <= 1'b1;
                     state      <= S_ERR;
                  end else begin
                     state      <= S_STREAM;
                  end
               end else begin
                  acc <= acc | chk_word;
                  idx <= idx + IDX_W'(1);
               end
            end

            S_STREAM: begin
               if (xfer) begin
                  dout_r       <= (bus.din ^ cur_key) & cur_mask;
                  dout_valid_r <= 1'b1;
                  idx          <= idx + IDX_W'(1);
               end else if (dout_valid_r && bus.dout_ready) begin
                  dout_valid_r <= 1'b0;
                  if (all_in)
                     state <= S_FIN;
               end
            end

            S_FIN:   state <= S_IDLE;
            S_ERR:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.din_ready  = din_ready_c;
   assign bus.dout       = dout_r;
   assign bus.dout_valid = dout_valid_r;
   assign bus.busy       = (state != S_IDLE);
   assign bus.done       = (state == S_FIN) || (state == S_ERR);
   assign bus.zero_key   = zero_key_r;
   assign bus.len_err    = len_err_r;

endmodule

// File: tb/tb_sm2_kdf_xor.sv
// Directed and randomized checks of sm2_kdf_xor against a bit-level reference of the keystream XOR.
module tb_sm2_kdf_xor;

   logic clk = 1'b0;
   logic rst;

   sm2_kdf_xor_if bus ();

   sm2_kdf_xor dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [1023:0] kin_v;
   logic [31:0]   din_tab [32];
   logic [31:0]   got [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bit i of the message counts from the MSB of word 0; bits at or beyond klen are zero.
   function automatic logic [31:0] model_word(input int w, input logic [31:0] d, input int klen,
                                              input logic [1023:0] k);
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < 32; b++) begin
         int pos;
         pos = 32 * w + b;
         if (pos < klen)
            r[31-b] = d[31-b] ^ k[1023-pos];
      end
      return r;
   endfunction

   function automatic bit any_key_bit(input int klen, input logic [1023:0] k);
      for (int j = 0; j < klen; j++)
         if (k[1023-j]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic run_op(input int klen, input int mode, input int kdelay, input int rst_at);
      logic [31:0] exp_q [$];
      logic [31:0] e;
      logic [31:0] held;
      bit          hold_chk = 1'b0;
      bit          len_bad;
      bit          zk_exp;
      int          nw;
      int          pushes = 0;
      int          pops = 0;
      int          rdy_cyc = -1;
      int          done_cyc = -1;
      int          stall_left = 3;

      len_bad = (klen == 0) || (klen > 1024);
      nw      = len_bad ? 0 : (klen + 31) / 32;
      zk_exp  = !len_bad && !any_key_bit(klen, kin_v);
      got.delete();

      bus.klen  = klen;
      bus.kin   = kin_v;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      #1 chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
      #1;

      for (int cyc = 1; cyc <= 3000; cyc++) begin
         bus.kin_valid = (cyc == kdelay);
         if (mode == 1)
            bus.dout_ready = ($urandom_range(0, 2) != 0);
         else if (mode == 2 && pushes >= 2 && stall_left > 0) begin
            bus.dout_ready = 1'b0;
            stall_left--;
         end else
            bus.dout_ready = 1'b1;
         bus.din_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.din       = din_tab[pushes % 32];
         #1;
         if (hold_chk) begin
            chk("dout_stable", bus.dout, held);
            chk("dout_valid_held", {31'd0, bus.dout_valid}, 32'd1);
         end
         if (bus.dout_valid && !bus.dout_ready)
            chk("din_ready_stalled", {31'd0, bus.din_ready}, 32'd0);
         if (bus.done) begin
            done_cyc = cyc;
            break;
         end
         if (bus.din_ready && rdy_cyc < 0)
            rdy_cyc = cyc;
         if (bus.dout_valid && bus.dout_ready) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
            chk($sformatf("dout_w%0d", pops), bus.dout, e);
            got.push_back(bus.dout);
            pops++;
         end
         if (bus.din_valid && bus.din_ready) begin
            exp_q.push_back(model_word(pushes, bus.din, klen, kin_v));
            pushes++;
         end
         hold_chk = bus.dout_valid && !bus.dout_ready;
         held     = bus.dout;
         if (rst_at >= 0 && pushes == rst_at) begin
            rst = 1'b1;
            #1;
            chk("rst_dout", bus.dout, 32'd0);
            chk("rst_flags", {25'd0, bus.dout_valid, bus.busy, bus.done, bus.zero_key,
                              bus.len_err, bus.din_ready, 1'b0}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            bus.kin_valid = 1'b0;
            bus.din_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end

      bus.kin_valid = 1'b0;
      bus.din_valid = 1'b0;
      chk("done_seen", {31'd0, done_cyc >= 0}, 32'd1);
      chk("zero_key", {31'd0, bus.zero_key}, {31'd0, zk_exp});
      chk("len_err", {31'd0, bus.len_err}, {31'd0, len_bad});
      chk("words_out", pops, (len_bad || zk_exp) ? 0 : nw);
      if (len_bad)
         chk("len_err_done_cyc", done_cyc, 1);
      else if (zk_exp) begin
         chk("check_cycles_err", done_cyc - kdelay, nw + 1);
         chk("no_din_ready", rdy_cyc, -1);
      end else
         chk("check_cycles_ok", rdy_cyc - kdelay, nw + 1);
      @(negedge clk);
      #1;
      chk("done_one_cycle", {30'd0, bus.done, bus.busy}, 32'd0);
      chk("flags_sticky", {30'd0, bus.zero_key, bus.len_err}, {30'd0, zk_exp, len_bad});
      @(negedge clk);
   endtask

   initial begin
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.klen       = '0;
      bus.kin        = '0;
      bus.kin_valid  = 1'b0;
      bus.din        = '0;
      bus.din_valid  = 1'b0;
      bus.dout_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_dout", bus.dout, 32'd0);
      chk("reset_flags", {25'd0, bus.dout_valid, bus.busy, bus.done, bus.zero_key,
                          bus.len_err, bus.din_ready, 1'b0}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // klen=256, key word i = 0x01010101*(i+1), din = word index
      for (int i = 0; i < 32; i++) begin
         kin_v[1023-32*i -: 32] = 32'h0101_0101 * (i + 1);
         din_tab[i] = i;
      end
      run_op(256, 0, 2, -1);

      // klen=40 against an all-ones key
      kin_v      = '1;
      din_tab[0] = 32'h1234_5678;
      din_tab[1] = 32'hABCD_EF01;
      run_op(40, 0, 1, -1);
      chk("k40_w0", got.size() > 0 ? got[0] : 32'hxxxx_xxxx, 32'hEDCB_A987);
      chk("k40_w1", got.size() > 1 ? got[1] : 32'hxxxx_xxxx, 32'h5400_0000);

      // klen=64 with the first two key words zero
      kin_v = '1;
      kin_v[1023 -: 64] = '0;
      run_op(64, 0, 3, -1);

      // klen=40 with only bit 40 set: the mask must hide it
      kin_v = '0;
      kin_v[1023-40] = 1'b1;
      run_op(40, 0, 1, -1);

      run_op(0, 0, 1, -1);
      run_op(1025, 0, 1, -1);

      // klen=128 with a three-cycle output stall mid-stream
      for (int i = 0; i < 32; i++) begin
         kin_v[1023-32*i -: 32] = $urandom;
         din_tab[i] = $urandom;
      end
      run_op(128, 2, 1, -1);

      // reset once word 2 has been accepted, then a clean rerun
      run_op(256, 0, 2, 3);
      run_op(256, 0, 2, -1);

      // boundaries and randomized lengths, keys, valid/ready gaps
      for (int r = 0; r < 12; r++) begin
         int kl;
         case (r)
            0:       kl = 1024;
            1:       kl = 1;
            2:       kl = 33;
            default: kl = $urandom_range(1, 1024);
         endcase
         for (int i = 0; i < 32; i++) begin
            kin_v[1023-32*i -: 32] = $urandom;
            din_tab[i] = $urandom;
         end
         if (r % 4 == 3)
            for (int j = 0; j < kl; j++) kin_v[1023-j] = 1'b0;
         run_op(kl, 1, $urandom_range(1, 4), -1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
